// File: rtl/parking_pkg.sv
// Shared constants for the parking slot manager: response status codes and default slot count.
package parking_pkg;

  localparam int NUM_SLOTS_DEF = 8;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_CONFLICT = 2'd1,
    ST_FULL     = 2'd2,
    ST_BAD_SLOT = 2'd3
  } status_e;

endpackage

// File: rtl/parking_free_slot_finder.sv
// Combinational priority encoder: lowest-index zero bit of the occupancy map, plus a found flag.
module parking_free_slot_finder #(
  parameter  int NUM_SLOTS = 8,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occupancy_i,
  output logic [SLOT_W-1:0]    free_idx_o,
  output logic                 found_o
);

  // Scanning downward leaves the lowest free index as the final assignment.
  always_comb begin
    free_idx_o = '0;
    found_o    = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        free_idx_o = SLOT_W'(i);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Occupancy bitmap with entry/exit requests over valid/ready; one-deep response buffer, latency 1.
// req_ready drops only while a response is held and the consumer is not taking it.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_exit,
  input  logic                 req_auto,
  input  logic [SLOT_W-1:0]    req_slot,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [SLOT_W-1:0]    rsp_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty
);

  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full_q, empty_q;
  logic                 rsp_vld_q, rsp_vld_d;
  status_e              st_q, st_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;

  logic              accept;
  logic              uses_slot;
  logic              bad_slot;
  logic [SLOT_W-1:0] free_idx;
  logic              free_found;

  parking_free_slot_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
    .occupancy_i (occ_q),
    .free_idx_o  (free_idx),
    .found_o     (free_found)
  );

  assign req_ready = !rsp_vld_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign uses_slot = req_exit || !req_auto;
  // Widened compare so non-power-of-two slot counts can reject unused codes.
  assign bad_slot  = ({1'b0, req_slot} >= (SLOT_W + 1)'(NUM_SLOTS));

  always_comb begin
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    rsp_vld_d = rsp_vld_q;
    st_d      = st_q;
    slot_d    = slot_q;
    if (rsp_vld_q && rsp_ready) begin
      rsp_vld_d = 1'b0;
    end
    if (accept) begin
      rsp_vld_d = 1'b1;
      slot_d    = req_slot;
      if (uses_slot && bad_slot) begin
        st_d = ST_BAD_SLOT;
      end else if (!req_exit && req_auto) begin
        if (full_q || !free_found) begin
          st_d   = ST_FULL;
          slot_d = '0;
        end else begin
          st_d            = ST_OK;
          slot_d          = free_idx;
          occ_d[free_idx] = 1'b1;
          cnt_d           = cnt_q - CNT_W'(1);
        end
      end else if (!req_exit) begin
        if (occ_q[req_slot]) begin
          st_d = ST_CONFLICT;
        end else begin
          st_d            = ST_OK;
          occ_d[req_slot] = 1'b1;
          cnt_d           = cnt_q - CNT_W'(1);
        end
      end else begin
        if (!occ_q[req_slot]) begin
          st_d = ST_CONFLICT;
        end else begin
          st_d            = ST_OK;
          occ_d[req_slot] = 1'b0;
          cnt_d           = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q     <= '0;
      cnt_q     <= CNT_W'(NUM_SLOTS);
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rsp_vld_q <= 1'b0;
      st_q      <= ST_OK;
      slot_q    <= '0;
    end else begin
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      full_q    <= (cnt_d == '0);
      empty_q   <= (cnt_d == CNT_W'(NUM_SLOTS));
      rsp_vld_q <= rsp_vld_d;
      st_q      <= st_d;
      slot_q    <= slot_d;
    end
  end

  assign rsp_valid  = rsp_vld_q;
  assign rsp_status = st_q;
  assign rsp_slot   = slot_q;
  assign occupancy  = occ_q;
  assign free_count = cnt_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboarded bench: driver pushes model predictions, monitor pops them as responses are consumed.
module tb_parking_slot_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_exit = 1'b0, req_auto = 1'b0;
  logic [2:0] req_slot = '0;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [1:0] rsp_status;
  logic [2:0] rsp_slot;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full, empty;

  logic       b_req_valid = 1'b0, b_req_ready, b_req_exit = 1'b0, b_req_auto = 1'b0;
  logic [2:0] b_req_slot = '0;
  logic       b_rsp_valid;
  logic [1:0] b_rsp_status;
  logic [2:0] b_rsp_slot;
  logic [5:0] b_occupancy;
  logic [2:0] b_free_count;
  logic       b_full, b_empty;

  always #5 clk = ~clk;

  parking_slot_manager #(.NUM_SLOTS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_exit(req_exit), .req_auto(req_auto), .req_slot(req_slot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_slot(rsp_slot), .occupancy(occupancy), .free_count(free_count),
    .full(full), .empty(empty)
  );

  parking_slot_manager #(.NUM_SLOTS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_exit(b_req_exit), .req_auto(b_req_auto), .req_slot(b_req_slot),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_status(b_rsp_status),
    .rsp_slot(b_rsp_slot), .occupancy(b_occupancy), .free_count(b_free_count),
    .full(b_full), .empty(b_empty)
  );

  typedef struct {
    logic [1:0] st;
    logic [2:0] slot;
    logic [7:0] occ;
    logic [3:0] cnt;
  } exp_t;

  exp_t     sb[$];
  bit [7:0] m_occ = '0;
  int       n_vec = 0;
  int       n_err = 0;
  int       mode  = 0;  // 0: always take responses, 1: random, 2: stall

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the parking rules applied to a plain bit array.
  function automatic exp_t model_apply(input bit ex, input bit au, input int unsigned s);
    exp_t e;
    int   lo;
    e.slot = 3'(s);
    if (!ex && au) begin
      lo = -1;
      for (int i = 7; i >= 0; i--) if (!m_occ[i]) lo = i;
      if (lo < 0) begin
        e.st = 2'd2; e.slot = 3'd0;
      end else begin
        m_occ[lo] = 1'b1; e.st = 2'd0; e.slot = 3'(lo);
      end
    end else if (s >= 8) begin
      e.st = 2'd3;
    end else if (!ex) begin
      if (m_occ[s]) e.st = 2'd1;
      else begin m_occ[s] = 1'b1; e.st = 2'd0; end
    end else begin
      if (!m_occ[s]) e.st = 2'd1;
      else begin m_occ[s] = 1'b0; e.st = 2'd0; end
    end
    e.occ = m_occ;
    e.cnt = 4'(8 - $countones(m_occ));
    return e;
  endfunction

  task automatic issue(input bit ex, input bit au, input logic [2:0] s);
    int waitc = 0;
    @(negedge clk); #1;
    req_valid = 1'b1; req_exit = ex; req_auto = au; req_slot = s;
    while (!req_ready && waitc < 100) begin
      @(negedge clk); #1;
      waitc++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL req_ready timeout: got 0 expected 1 at %0t", $time);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(model_apply(ex, au, int'(s)));
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Monitor: owns rsp_ready and checks every response at the cycle it is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected rsp: got status %0d with no request outstanding", rsp_status);
        end else begin
          e = sb.pop_front();
          chk("rsp_status", rsp_status, e.st);
          chk("rsp_slot",   rsp_slot,   e.slot);
          chk("occupancy",  occupancy,  e.occ);
          chk("free_count", free_count, e.cnt);
          chk("full",       full,       e.occ == 8'hFF);
          chk("empty",      empty,      e.occ == 8'h00);
        end
      end
    end
  end

  initial begin
    int drain;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset occupancy", occupancy, 8'h00);
    chk("reset free_count", free_count, 8);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset req_ready", req_ready, 1);
    chk("reset6 free_count", b_free_count, 6);

    // Six-slot instance: unused slot codes are rejected, auto entry ignores req_slot.
    b_req_valid = 1'b1; b_req_exit = 1'b0; b_req_auto = 1'b0; b_req_slot = 3'd7;
    @(negedge clk);
    chk("n6 bad entry status", b_rsp_status, 3);
    chk("n6 bad entry slot", b_rsp_slot, 7);
    chk("n6 bad entry occ", b_occupancy, 6'h00);
    chk("n6 bad entry cnt", b_free_count, 6);
    b_req_exit = 1'b1; b_req_slot = 3'd6;
    @(negedge clk);
    chk("n6 bad exit status", b_rsp_status, 3);
    chk("n6 bad exit valid", b_rsp_valid, 1);
    b_req_exit = 1'b0; b_req_auto = 1'b1; b_req_slot = 3'd7;
    @(negedge clk);
    chk("n6 auto status", b_rsp_status, 0);
    chk("n6 auto slot", b_rsp_slot, 0);
    chk("n6 auto occ", b_occupancy, 6'h01);
    chk("n6 auto cnt", b_free_count, 5);
    b_req_valid = 1'b0;
    @(negedge clk);
    chk("n6 rsp drained", b_rsp_valid, 0);

    issue(0, 0, 3'd3); #1;
    chk("enter3 occ", occupancy, 8'h08);
    chk("enter3 cnt", free_count, 7);
    issue(1, 0, 3'd3); #1;
    chk("exit3 occ", occupancy, 8'h00);
    chk("exit3 cnt", free_count, 8);

    issue(0, 0, 3'd5);
    issue(0, 0, 3'd5); #1;
    chk("dup5 status", rsp_status, 1);
    issue(1, 0, 3'd2); #1;
    chk("exit empty status", rsp_status, 1);
    chk("dup5 occ", occupancy, 8'h20);
    issue(1, 0, 3'd5);

    for (int i = 0; i < 9; i++) issue(0, 1, 3'($urandom_range(0, 7)));
    #1;
    chk("9th auto status", rsp_status, 2);
    chk("auto fill occ", occupancy, 8'hFF);
    chk("auto fill full", full, 1);
    issue(1, 0, 3'd4);
    issue(0, 1, 3'd0); #1;
    chk("refill slot", rsp_slot, 4);
    idle();

    // Stall the consumer: the held response and req_ready must stay put.
    repeat (2) @(negedge clk);
    mode = 2;
    issue(1, 0, 3'd4); #1;
    req_exit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("stall rsp_valid", rsp_valid, 1);
      chk("stall req_ready", req_ready, 0);
      chk("stall status", rsp_status, 0);
      chk("stall slot", rsp_slot, 4);
      chk("stall occ", occupancy, 8'hEF);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst pending rsp_valid", rsp_valid, 0);
    chk("rst pending occ", occupancy, 8'h00);
    chk("rst pending cnt", free_count, 8);
    chk("rst pending empty", empty, 1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    m_occ = '0;

    mode = 1;
    for (int i = 0; i < 400; i++)
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    idle();
    mode = 0;
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    @(negedge clk);
    chk("drain outstanding", sb.size(), 0);
    chk("drain rsp_valid", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
- Registered, parametrised successor to the combinational occupancy-toggle logic.
- Holds the parking occupancy bitmap for NUM_SLOTS slots and serves entry/exit requests over a valid/ready handshake.
- Validates each request, supports explicit-slot and auto-assign entry, and returns a status response.
- Maintains a free-slot count and full/empty flags for the gate controller and display blocks.

Parameters:
- NUM_SLOTS, 8, number of parking slots (2..64); need not be a power of two.
- SLOT_W, $clog2(NUM_SLOTS), derived localparam: slot index width.
- CNT_W, $clog2(NUM_SLOTS+1), derived localparam: free-count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_exit  in  1  0 = entry, 1 = exit.
- req_auto  in  1  entry only: ignore req_slot and take the lowest-index free slot.
- req_slot  in  SLOT_W  binary slot index.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_status  out  2  0 OK, 1 CONFLICT, 2 FULL, 3 BAD_SLOT.
- rsp_slot  out  SLOT_W  slot that was acted on; the assigned slot for auto entry.
- occupancy  out  NUM_SLOTS  bit i = 1 means slot i is occupied.
- free_count  out  CNT_W  number of zero bits in occupancy.
- full  out  1  free_count == 0.
- empty  out  1  free_count == NUM_SLOTS.

Behaviour:
- Reset (rst_n low at a clk edge):
  - occupancy = 0, free_count = NUM_SLOTS, full = 0, empty = 1.
  - rsp_valid = 0, rsp_status = 0, rsp_slot = 0.
  - Any pending response is dropped; a request presented in that cycle is ignored.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single-entry response buffer, combinational ready).
  - Acceptance happens when req_valid && req_ready at a rising edge.
- Timing:
  - occupancy, free_count, full, empty and the response register all update on the accepting edge.
  - rsp_valid is high from the next cycle (latency 1).
  - The response is held stable until rsp_ready is sampled high.
  - Back-to-back: with rsp_ready tied high, one request per cycle is sustained.
- Evaluation priority for an accepted request:
  1. Slot check (only when the request uses req_slot, i.e. exit, or entry with req_auto = 0): req_slot >= NUM_SLOTS gives BAD_SLOT, no state change.
  2. Auto entry with full = 1: FULL, no change, rsp_slot = 0.
  3. Explicit entry to an occupied slot: CONFLICT, no change.
  4. Exit from an empty slot: CONFLICT, no change.
  5. Otherwise OK:
     - Entry: set the bit, free_count - 1.
     - Exit: clear the bit, free_count + 1.
     - Auto entry: set the lowest-index zero bit and return that index in rsp_slot.
  - req_auto is ignored when req_exit = 1.
- Count integrity:
  - free_count never wraps; only legal operations change it.
  - free_count always equals NUM_SLOTS minus popcount(occupancy).
  - full and empty are registered, derived from the next-state count.
- Requests are decided against occupancy as of the accepting edge.
  - Two consecutive requests to the same slot see the first one's update.
  - The second of two same-slot entries returns CONFLICT.
- No state machine beyond the response buffer. Its two states:
  - IDLE (rsp_valid = 0): goes to HOLD on accept.
  - HOLD (rsp_valid = 1): stays in HOLD on accept && rsp_ready (new response replaces the old); goes to IDLE on rsp_ready without accept; stays otherwise.

Decomposition:
- Shared package parking_pkg:
  - Status enum constants ST_OK, ST_CONFLICT, ST_FULL, ST_BAD_SLOT.
  - NUM_SLOTS default value.
- One sub-module, parking_free_slot_finder: combinational priority encoder over ~occupancy, returning the lowest free index plus a found flag.
- Decode, check and update logic stays in the top module.

Test Plan:
- Reset then idle -> occupancy = 0x00, free_count = 8, empty = 1, full = 0, rsp_valid = 0.
- Explicit entry slot 3, then exit slot 3, rsp_ready = 1:
  - Responses OK/3 then OK/3.
  - occupancy 0x08 after the first, 0x00 after the second.
  - free_count 7, then 8.
- Entry slot 5 twice back-to-back -> OK then CONFLICT; occupancy = 0x20; exit from slot 2 -> CONFLICT, no change.
- 8 auto entries then a 9th, NUM_SLOTS = 8:
  - rsp_slot 0..7 in order, then FULL on the 9th.
  - occupancy = 0xFF, full = 1.
  - Exit slot 4, then auto entry -> rsp_slot = 4.
- NUM_SLOTS = 6, explicit entry slot 7 -> BAD_SLOT; occupancy unchanged; free_count = 6.
- Backpressure:
  - Hold rsp_ready = 0 after an entry -> req_ready = 0 and the response stays stable for 3 cycles.
  - Assert rst_n = 0 with the response pending -> rsp_valid = 0 and occupancy = 0 next cycle.
